// File: rtl/bj_round_ctrl.sv
// Blackjack round sequencer: debounced-edge key pulses, card fetch handshake,
// deal / player / dealer sequencing, result resolution and saturating tallies.
module bj_round_ctrl #(
  parameter int DEALER_STAND = 17,
  parameter int BUST_LIMIT   = 21
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       hit_n,
  input  logic       stand_n,
  input  logic       card_valid,
  input  logic [3:0] card_value,
  output logic       card_req,
  output logic [4:0] phand,
  output logic [4:0] dhand,
  output logic [2:0] state_out,
  output logic [1:0] result,
  output logic [3:0] win_cnt,
  output logic [3:0] loss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_DEAL    = 3'b001,
    S_PLAYER  = 3'b010,
    S_P_DRAW  = 3'b011,
    S_DEALER  = 3'b100,
    S_D_DRAW  = 3'b101,
    S_RESOLVE = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  localparam logic [4:0] STAND_L = 5'(DEALER_STAND);
  localparam logic [4:0] BUST_L  = 5'(BUST_LIMIT);

  function automatic logic [4:0] card_pts(input logic [3:0] v);
    case (v)
      4'd1:                                                    card_pts = 5'd1;
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10:   card_pts = {1'b0, v};
      default:                                                 card_pts = 5'd10;
    endcase
  endfunction

  // An ace is promoted to 11 only while that cannot bust the hand.
  function automatic logic [4:0] hand_total(input logic [4:0] hard, input logic ace);
    if (ace && (hard <= 5'd11)) hand_total = hard + 5'd10;
    else                        hand_total = hard;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  hit_sync_q, stand_sync_q;
  logic [4:0]  p_hard_q, p_hard_d, d_hard_q, d_hard_d;
  logic        p_ace_q, p_ace_d, d_ace_q, d_ace_d;
  logic [1:0]  deal_idx_q, deal_idx_d;
  logic [1:0]  result_q, result_d;
  logic [3:0]  win_q, win_d, loss_q, loss_d;

  logic        hit_p, stand_p, accept;
  logic [4:0]  pts, p_tot, d_tot, p_tot_nxt;
  logic        is_ace;

  // Synchronizer stage 3 holds the previous synchronized level for edge detection.
  assign hit_p   = hit_sync_q[2]   & ~hit_sync_q[1];
  assign stand_p = stand_sync_q[2] & ~stand_sync_q[1];
  assign accept  = card_req & card_valid;
  assign pts     = card_pts(card_value);
  assign is_ace  = (card_value == 4'd1);
  assign p_tot   = hand_total(p_hard_q, p_ace_q);
  assign d_tot   = hand_total(d_hard_q, d_ace_q);
  assign p_tot_nxt = hand_total(p_hard_d, p_ace_d);

  assign phand    = p_tot;
  assign dhand    = d_tot;
  assign state_out = state_q;
  assign result   = result_q;
  assign win_cnt  = win_q;
  assign loss_cnt = loss_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (hit_p) state_d = S_DEAL;
        else       state_d = state_q;
      end
      S_DEAL: begin
        if (accept && (deal_idx_q == 2'd3)) state_d = (p_tot == BUST_L) ? S_DEALER : S_PLAYER;
        else                                state_d = S_DEAL;
      end
      S_PLAYER: begin
        if (hit_p)        state_d = S_P_DRAW;
        else if (stand_p) state_d = S_DEALER;
        else              state_d = S_PLAYER;
      end
      S_P_DRAW: begin
        if (!accept)                  state_d = S_P_DRAW;
        else if (p_tot_nxt > BUST_L)  state_d = S_RESOLVE;
        else if (p_tot_nxt == BUST_L) state_d = S_DEALER;
        else                          state_d = S_PLAYER;
      end
      S_DEALER: begin
        if (d_tot >= STAND_L) state_d = S_RESOLVE;
        else                  state_d = S_D_DRAW;
      end
      S_D_DRAW: begin
        if (accept) state_d = S_DEALER;
        else        state_d = S_D_DRAW;
      end
      S_RESOLVE: state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: card request is asserted in every fetching state.
  always_comb begin
    card_req = 1'b0;
    case (state_q)
      S_DEAL, S_P_DRAW, S_D_DRAW: card_req = 1'b1;
      default:                    card_req = 1'b0;
    endcase
  end

  // Hand, deal index, result and tally next-state.
  always_comb begin
    p_hard_d   = p_hard_q;
    p_ace_d    = p_ace_q;
    d_hard_d   = d_hard_q;
    d_ace_d    = d_ace_q;
    deal_idx_d = deal_idx_q;
    result_d   = result_q;
    win_d      = win_q;
    loss_d     = loss_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (hit_p) begin
          p_hard_d   = 5'd0;
          p_ace_d    = 1'b0;
          d_hard_d   = 5'd0;
          d_ace_d    = 1'b0;
          deal_idx_d = 2'd0;
          result_d   = 2'b00;
        end else begin
          result_d   = result_q;
        end
      end
      S_DEAL: begin
        if (accept) begin
          deal_idx_d = deal_idx_q + 2'd1;
          if (!deal_idx_q[0]) begin
            p_hard_d = p_hard_q + pts;
            p_ace_d  = p_ace_q | is_ace;
          end else begin
            d_hard_d = d_hard_q + pts;
            d_ace_d  = d_ace_q | is_ace;
          end
        end else begin
          deal_idx_d = deal_idx_q;
        end
      end
      S_P_DRAW: begin
        if (accept) begin
          p_hard_d = p_hard_q + pts;
          p_ace_d  = p_ace_q | is_ace;
        end else begin
          p_hard_d = p_hard_q;
        end
      end
      S_D_DRAW: begin
        if (accept) begin
          d_hard_d = d_hard_q + pts;
          d_ace_d  = d_ace_q | is_ace;
        end else begin
          d_hard_d = d_hard_q;
        end
      end
      S_RESOLVE: begin
        if (p_tot > BUST_L)      result_d = 2'b10;
        else if (d_tot > BUST_L) result_d = 2'b01;
        else if (p_tot > d_tot)  result_d = 2'b01;
        else if (p_tot < d_tot)  result_d = 2'b10;
        else                     result_d = 2'b11;
        if ((result_d == 2'b01) && (win_q != 4'd15))       win_d  = win_q + 4'd1;
        else if ((result_d == 2'b10) && (loss_q != 4'd15)) loss_d = loss_q + 4'd1;
        else                                               win_d  = win_q;
      end
      default: begin
        result_d = result_q;
      end
    endcase
  end

  // Datapath and synchronizer registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_sync_q   <= 3'b111;
      stand_sync_q <= 3'b111;
      p_hard_q     <= 5'd0;
      p_ace_q      <= 1'b0;
      d_hard_q     <= 5'd0;
      d_ace_q      <= 1'b0;
      deal_idx_q   <= 2'd0;
      result_q     <= 2'b00;
      win_q        <= 4'd0;
      loss_q       <= 4'd0;
    end else begin
      hit_sync_q   <= {hit_sync_q[1:0], hit_n};
      stand_sync_q <= {stand_sync_q[1:0], stand_n};
      p_hard_q     <= p_hard_d;
      p_ace_q      <= p_ace_d;
      d_hard_q     <= d_hard_d;
      d_ace_q      <= d_ace_d;
      deal_idx_q   <= deal_idx_d;
      result_q     <= result_d;
      win_q        <= win_d;
      loss_q       <= loss_d;
    end
  end

endmodule

// File: tb/tb_bj_round_ctrl.sv
// Self-checking bench for bj_round_ctrl: directed table rows, randomized rounds
// against a card-list blackjack model, and multi-cycle corner sequences.
module tb_bj_round_ctrl;

  localparam int ST_IDLE = 0, ST_DEAL = 1, ST_PLAYER = 2, ST_PDRAW = 3, ST_DONE = 7;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       hit_n = 1'b1;
  logic       stand_n = 1'b1;
  logic       card_valid = 1'b0;
  logic [3:0] card_value = 4'd0;
  logic       card_req;
  logic [4:0] phand, dhand;
  logic [2:0] state_out;
  logic [1:0] result;
  logic [3:0] win_cnt, loss_cnt;

  bj_round_ctrl dut (
    .clock(clock), .reset_n(reset_n), .hit_n(hit_n), .stand_n(stand_n),
    .card_valid(card_valid), .card_value(card_value), .card_req(card_req),
    .phand(phand), .dhand(dhand), .state_out(state_out), .result(result),
    .win_cnt(win_cnt), .loss_cnt(loss_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int mwin = 0, mloss = 0;

  logic [3:0] feed_q[$];
  bit         feed_en = 1'b1;
  bit         pend = 1'b0;

  // Card source: presents the queue head while requested; a card shown across
  // a rising edge with card_req high was accepted, so it is popped afterwards.
  always @(negedge clock) begin
    if (pend && feed_q.size() > 0) void'(feed_q.pop_front());
    pend = 1'b0;
    if (feed_en && card_req && feed_q.size() > 0) begin
      card_valid = 1'b1;
      card_value = feed_q[0];
      pend = 1'b1;
    end else begin
      card_valid = 1'b0;
      card_value = 4'($urandom);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input int s);
    int n;
    n = 0;
    while (int'(state_out) != s && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("wait_state", int'(state_out), s);
  endtask

  task automatic press(input bit h, input bit s);
    hit_n = ~h;
    stand_n = ~s;
    repeat (3) @(posedge clock);
    @(negedge clock);
    hit_n = 1'b1;
    stand_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    hit_n = 1'b1;
    stand_n = 1'b1;
    feed_q.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    mwin = 0;
    mloss = 0;
    @(negedge clock);
  endtask

  task automatic run_round(input int nh, input bit st);
    press(1'b1, 1'b0);
    for (int i = 0; i < nh; i++) begin
      wait_state(ST_PLAYER);
      press(1'b1, 1'b0);
    end
    if (st) begin
      wait_state(ST_PLAYER);
      press(1'b0, 1'b1);
    end
    wait_state(ST_DONE);
    feed_q.delete();
  endtask

  function automatic int pts_of(input int v);
    if (v == 1) return 1;
    if (v >= 2 && v <= 10) return v;
    return 10;
  endfunction

  function automatic int total_of(input int sum, input bit ace);
    return (ace && sum <= 11) ? sum + 10 : sum;
  endfunction

  int mc[32];

  // Plays a whole round from the card list: player hits below 'stop', dealer to 17.
  task automatic model_round(input int stop, output int nh, output bit st,
                             output int ep, output int ed, output int er);
    int k, ps, ds;
    bit pa, da;
    k  = 4;
    ps = pts_of(mc[0]) + pts_of(mc[2]);
    pa = (mc[0] == 1) || (mc[2] == 1);
    ds = pts_of(mc[1]) + pts_of(mc[3]);
    da = (mc[1] == 1) || (mc[3] == 1);
    nh = 0;
    st = 1'b0;
    while (total_of(ps, pa) < 21) begin
      if (total_of(ps, pa) < stop) begin
        ps += pts_of(mc[k]);
        pa |= (mc[k] == 1);
        k++;
        nh++;
      end else begin
        st = 1'b1;
        break;
      end
    end
    ep = total_of(ps, pa);
    if (ep <= 21) begin
      while (total_of(ds, da) < 17) begin
        ds += pts_of(mc[k]);
        da |= (mc[k] == 1);
        k++;
      end
    end
    ed = total_of(ds, da);
    if (ep > 21)      er = 2;
    else if (ed > 21) er = 1;
    else if (ep > ed) er = 1;
    else if (ep < ed) er = 2;
    else              er = 3;
  endtask

  typedef struct {
    int c[6];
    int nh;
    bit st;
    int ep, ed, er, ew, el;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int nh, ep, ed, er, stop;
    bit st;

    tbl[0] = '{c: '{1, 5, 13, 9, 3, 0},  nh: 0, st: 1'b0, ep: 21, ed: 17, er: 1, ew: 1, el: 0};
    tbl[1] = '{c: '{10, 6, 7, 10, 9, 0}, nh: 1, st: 1'b0, ep: 26, ed: 16, er: 2, ew: 1, el: 1};
    tbl[2] = '{c: '{10, 10, 8, 7, 0, 0}, nh: 0, st: 1'b1, ep: 18, ed: 17, er: 1, ew: 2, el: 1};
    tbl[3] = '{c: '{10, 10, 7, 7, 0, 0}, nh: 0, st: 1'b1, ep: 17, ed: 17, er: 3, ew: 2, el: 1};

    do_reset();
    chk("rst_state", int'(state_out), ST_IDLE);
    chk("rst_card_req", int'(card_req), 0);
    chk("rst_phand", int'(phand), 0);
    chk("rst_dhand", int'(dhand), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_win", int'(win_cnt), 0);
    chk("rst_loss", int'(loss_cnt), 0);

    // Directed rounds.
    for (int r = 0; r < 4; r++) begin
      foreach (tbl[r].c[i]) feed_q.push_back(4'(tbl[r].c[i]));
      run_round(tbl[r].nh, tbl[r].st);
      chk("tbl_phand", int'(phand), tbl[r].ep);
      chk("tbl_dhand", int'(dhand), tbl[r].ed);
      chk("tbl_result", int'(result), tbl[r].er);
      chk("tbl_win", int'(win_cnt), tbl[r].ew);
      chk("tbl_loss", int'(loss_cnt), tbl[r].el);
      chk("tbl_card_req", int'(card_req), 0);
      mwin = tbl[r].ew;
      mloss = tbl[r].el;
    end

    // Randomized rounds against the model.
    for (int r = 0; r < 20; r++) begin
      foreach (mc[i]) begin
        mc[i] = $urandom_range(0, 15);
        feed_q.push_back(4'(mc[i]));
      end
      stop = $urandom_range(12, 21);
      model_round(stop, nh, st, ep, ed, er);
      if (er == 1 && mwin < 15) mwin++;
      if (er == 2 && mloss < 15) mloss++;
      run_round(nh, st);
      chk("rnd_phand", int'(phand), ep);
      chk("rnd_dhand", int'(dhand), ed);
      chk("rnd_result", int'(result), er);
      chk("rnd_win", int'(win_cnt), mwin);
      chk("rnd_loss", int'(loss_cnt), mloss);
    end

    // Key press during DEAL is dropped; result clears when a new round starts.
    feed_en = 1'b0;
    press(1'b1, 1'b0);
    chk("start_state", int'(state_out), ST_DEAL);
    chk("start_result_clr", int'(result), 0);
    press(1'b1, 1'b0);
    chk("deal_press_state", int'(state_out), ST_DEAL);
    chk("deal_press_phand", int'(phand), 0);
    chk("deal_press_dhand", int'(dhand), 0);
    feed_q.push_back(4'd10);
    feed_q.push_back(4'd5);
    feed_q.push_back(4'd4);
    feed_q.push_back(4'd6);
    feed_en = 1'b1;
    wait_state(ST_PLAYER);
    chk("deal_phand", int'(phand), 14);
    chk("deal_dhand", int'(dhand), 11);

    // Simultaneous hit and stand: hit wins; then the card is withheld.
    press(1'b1, 1'b1);
    chk("both_press_state", int'(state_out), ST_PDRAW);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("withhold_card_req", int'(card_req), 1);
      chk("withhold_phand", int'(phand), 14);
    end

    // Asynchronous reset mid-handshake, checked before any further clock edge.
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_card_req", int'(card_req), 0);
    chk("arst_state", int'(state_out), ST_IDLE);
    chk("arst_phand", int'(phand), 0);
    chk("arst_dhand", int'(dhand), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_win", int'(win_cnt), 0);
    chk("arst_loss", int'(loss_cnt), 0);
    do_reset();

    // Sixteen wins (dealer busts at 26): tally saturates at 15.
    for (int r = 0; r < 16; r++) begin
      feed_q.push_back(4'd10);
      feed_q.push_back(4'd6);
      feed_q.push_back(4'd10);
      feed_q.push_back(4'd10);
      feed_q.push_back(4'd10);
      run_round(0, 1'b1);
      chk("sat_result", int'(result), 1);
    end
    chk("sat_win", int'(win_cnt), 15);
    chk("sat_loss", int'(loss_cnt), 0);
    chk("sat_dhand", int'(dhand), 26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
